// File: rtl/ysyx_22040931_ifu_resp_if.sv
// Memory-side bus of the instruction fetch responder.
// master: request valid/address out; ready, response valid/data/err in.
interface ysyx_22040931_ifu_resp_if #(
  parameter int PC_W = 64
) ();
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [PC_W-1:0] mem_addr;
  logic            mem_rsp_valid;
  logic [63:0]     mem_rsp_data;
  logic            mem_rsp_err;

  modport master (
    output mem_req_valid,
    output mem_addr,
    input  mem_req_ready,
    input  mem_rsp_valid,
    input  mem_rsp_data,
    input  mem_rsp_err
  );

  modport slave (
    input  mem_req_valid,
    input  mem_addr,
    output mem_req_ready,
    output mem_rsp_valid,
    output mem_rsp_data,
    output mem_rsp_err
  );
endinterface

// File: rtl/ysyx_22040931_ifu_resp.sv
// Fetch responder: takes a PC from IF, does one aligned 64-bit read,
// hands {pc, instr, err} to ID. Ports: clock/reset, flush, IF pc
// handshake, mem bus (master modport), ID valid/ready handshake.
module ysyx_22040931_ifu_resp #(
  parameter int PC_W   = 64,
  parameter int INST_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              pc_valid,
  input  logic [PC_W-1:0]   if_pc,
  output logic              if_ready,
  ysyx_22040931_ifu_resp_if.master mem,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [PC_W-1:0]   id_pc,
  output logic [INST_W-1:0] id_instr,
  output logic              id_err
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DROP
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic            kill_q;
  logic            kill_d;
  logic [PC_W-1:0] pc_q;
  logic            accept;
  logic            ld_id;

  assign if_ready = (state_q == IDLE)
                  | ((state_q == HOLD) & id_ready);
  assign accept   = pc_valid & if_ready & ~flush;

  assign mem.mem_req_valid = (state_q == REQ);
  assign mem.mem_addr      = {pc_q[PC_W-1:3], 3'b000};
  assign id_valid          = (state_q == HOLD);

  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    ld_id   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = REQ;
      end
      REQ: begin
        // The request stays up until taken; a flush meanwhile
        // only marks the fetch so its data is thrown away.
        if (mem.mem_req_ready) begin
          state_d = (kill_q | flush) ? DROP : WAIT;
        end else if (flush) begin
          kill_d = 1'b1;
        end
      end
      WAIT: begin
        if (flush) begin
          state_d = mem.mem_rsp_valid ? IDLE : DROP;
        end else if (mem.mem_rsp_valid) begin
          ld_id   = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (flush) begin
          state_d = IDLE;
        end else if (id_ready) begin
          state_d = accept ? REQ : IDLE;
        end
      end
      DROP: begin
        if (mem.mem_rsp_valid) begin
          state_d = IDLE;
          kill_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) kill_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q     <= '0;
      id_pc    <= '0;
      id_instr <= '0;
      id_err   <= 1'b0;
    end else begin
      if (accept) pc_q <= if_pc;
      if (ld_id) begin
        id_pc    <= pc_q;
        id_instr <= pc_q[2] ? mem.mem_rsp_data[63:32]
                            : mem.mem_rsp_data[31:0];
        id_err   <= mem.mem_rsp_err;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22040931_ifu_resp.sv
// Bench for ysyx_22040931_ifu_resp: vector table, corner sequences,
// then random traffic against a fetch-level reference model.
module tb_ysyx_22040931_ifu_resp;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        pc_valid;
  logic [63:0] if_pc;
  logic        if_ready;
  logic        id_valid;
  logic        id_ready;
  logic [63:0] id_pc;
  logic [31:0] id_instr;
  logic        id_err;

  ysyx_22040931_ifu_resp_if #(.PC_W(64)) mif ();

  ysyx_22040931_ifu_resp #(.PC_W(64), .INST_W(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .pc_valid (pc_valid),
    .if_pc    (if_pc),
    .if_ready (if_ready),
    .mem      (mif),
    .id_valid (id_valid),
    .id_ready (id_ready),
    .id_pc    (id_pc),
    .id_instr (id_instr),
    .id_err   (id_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        fl;
    logic        pv;
    logic [63:0] pc;
    logic        ir;
    logic        rr;
    logic        rv;
    logic [63:0] rd;
    logic        re;
    logic        e_ifr;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_idv;
    logic [63:0] e_pc;
    logic [31:0] e_ins;
    logic        e_err;
  } vec_t;

  vec_t tbl[16];
  int   n_vec;
  int   n_err;

  // reference model state (fetch level)
  logic        m_req;
  logic        m_out;
  logic        m_hold;
  logic        m_live;
  logic [63:0] m_pc;
  logic [63:0] h_pc;
  logic [31:0] h_ins;
  logic        h_err;
  logic        mem_busy;
  int          mem_wait;
  logic [63:0] mem_data;
  logic        mem_err;

  function automatic vec_t mk(
    input logic fl, pv, input logic [63:0] pc,
    input logic ir, rr, rv, input logic [63:0] rd,
    input logic re, e_ifr, e_req, input logic [63:0] e_addr,
    input logic e_idv, input logic [63:0] e_pc,
    input logic [31:0] e_ins, input logic e_err);
    vec_t v;
    v.fl = fl; v.pv = pv; v.pc = pc; v.ir = ir;
    v.rr = rr; v.rv = rv; v.rd = rd; v.re = re;
    v.e_ifr = e_ifr; v.e_req = e_req; v.e_addr = e_addr;
    v.e_idv = e_idv; v.e_pc = e_pc; v.e_ins = e_ins;
    v.e_err = e_err;
    return v;
  endfunction

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    return {a[31:0] ^ 32'hA5A5_0F0F, ~a[31:0]};
  endfunction

  task automatic chk1(input string nm, input logic act,
                      input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk64(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic fl, pv, input logic [63:0] pc,
                     input logic ir, rr, rv, input logic [63:0] rd,
                     input logic re);
    flush             = fl;
    pc_valid          = pv;
    if_pc             = pc;
    id_ready          = ir;
    mif.mem_req_ready = rr;
    mif.mem_rsp_valid = rv;
    mif.mem_rsp_data  = rd;
    mif.mem_rsp_err   = re;
  endtask

  task automatic idle();
    drv(0, 0, 64'h0, 0, 0, 0, 64'h0, 0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [63:0] d1;
    logic [63:0] d2;
    logic [63:0] rpc;
    logic        rfl, rpv, rir, rrr, rrv, rre;
    logic [63:0] rrd;
    logic        e_ifr;
    logic        acc;
    n_vec = 0;
    n_err = 0;
    d1 = 64'h00100093_00000413;
    d2 = 64'h11111111_00A00513;
    reset = 1'b0;
    idle();

    // Cycle-by-cycle: basic fetch, 5-cycle backpressure with
    // same-cycle hand-off, back-to-back fetch, error response.
    tbl[0]  = mk(0,1,64'h80000004,0,0,0,0,0,
                 1,0,0,0,0,0,0);
    tbl[1]  = mk(0,0,0,0,1,0,0,0,
                 0,1,64'h80000000,0,0,0,0);
    tbl[2]  = mk(0,0,0,0,0,1,d1,0,
                 0,0,0,0,0,0,0);
    for (int i = 3; i < 8; i++)
      tbl[i] = mk(0,1,64'h80000008,0,0,0,0,0,
                  0,0,0,1,64'h80000004,32'h00100093,0);
    tbl[8]  = mk(0,1,64'h80000008,1,0,0,0,0,
                 1,0,0,1,64'h80000004,32'h00100093,0);
    tbl[9]  = mk(0,0,0,0,1,0,0,0,
                 0,1,64'h80000008,0,0,0,0);
    tbl[10] = mk(0,0,0,0,0,1,d2,0,
                 0,0,0,0,0,0,0);
    tbl[11] = mk(0,1,64'h80000010,1,0,0,0,0,
                 1,0,0,1,64'h80000008,32'h00A00513,0);
    tbl[12] = mk(0,0,0,0,1,0,0,0,
                 0,1,64'h80000010,0,0,0,0);
    tbl[13] = mk(0,0,0,0,0,1,64'h0,1,
                 0,0,0,0,0,0,0);
    tbl[14] = mk(0,0,0,1,0,0,0,0,
                 1,0,0,1,64'h80000010,32'h0,1);
    tbl[15] = mk(0,0,0,0,0,0,0,0,
                 1,0,0,0,0,0,0);

    tick();
    tick();
    chk1("rst req_valid", mif.mem_req_valid, 1'b0);
    chk1("rst id_valid", id_valid, 1'b0);
    chk64("rst mem_addr", mif.mem_addr, 64'h0);
    chk64("rst id_pc", id_pc, 64'h0);
    chk64("rst id_instr", 64'(id_instr), 64'h0);
    chk1("rst id_err", id_err, 1'b0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) begin
      drv(tbl[i].fl, tbl[i].pv, tbl[i].pc, tbl[i].ir,
          tbl[i].rr, tbl[i].rv, tbl[i].rd, tbl[i].re);
      #2;
      chk1($sformatf("v%0d if_ready", i), if_ready, tbl[i].e_ifr);
      chk1($sformatf("v%0d req_valid", i), mif.mem_req_valid,
           tbl[i].e_req);
      chk1($sformatf("v%0d id_valid", i), id_valid, tbl[i].e_idv);
      if (tbl[i].e_req)
        chk64($sformatf("v%0d mem_addr", i), mif.mem_addr,
              tbl[i].e_addr);
      if (tbl[i].e_idv) begin
        chk64($sformatf("v%0d id_pc", i), id_pc, tbl[i].e_pc);
        chk64($sformatf("v%0d id_instr", i), 64'(id_instr),
              64'(tbl[i].e_ins));
        chk1($sformatf("v%0d id_err", i), id_err, tbl[i].e_err);
      end
      tick();
    end

    // Flush while the request is stalled.
    drv(0, 1, 64'h80000020, 0, 0, 0, 64'h0, 0);
    #2; chk1("freq accept rdy", if_ready, 1'b1);
    tick();
    idle(); #2; chk1("freq req c1", mif.mem_req_valid, 1'b1);
    tick();
    drv(1, 0, 64'h0, 0, 0, 0, 64'h0, 0);
    #2; chk1("freq req c2", mif.mem_req_valid, 1'b1);
    tick();
    idle(); #2; chk1("freq req c3", mif.mem_req_valid, 1'b1);
    tick();
    drv(0, 0, 64'h0, 0, 1, 0, 64'h0, 0);
    #2; chk1("freq req hs", mif.mem_req_valid, 1'b1);
    tick();
    drv(0, 0, 64'h0, 0, 0, 1, 64'h1234, 0);
    #2;
    chk1("freq drop req", mif.mem_req_valid, 1'b0);
    chk1("freq drop idv", id_valid, 1'b0);
    chk1("freq drop ifr", if_ready, 1'b0);
    tick();
    idle(); #2;
    chk1("freq end idv", id_valid, 1'b0);
    chk1("freq end ifr", if_ready, 1'b1);
    tick();

    // Flush while waiting; response arrives two cycles later.
    drv(0, 1, 64'h80000030, 0, 0, 0, 64'h0, 0);
    tick();
    drv(0, 0, 64'h0, 0, 1, 0, 64'h0, 0);
    tick();
    drv(1, 0, 64'h0, 0, 0, 0, 64'h0, 0);
    #2; chk1("fwait idv0", id_valid, 1'b0);
    tick();
    idle(); #2; chk1("fwait ifr", if_ready, 1'b0);
    tick();
    drv(0, 0, 64'h0, 0, 0, 1, 64'h5555, 0);
    #2; chk1("fwait idv1", id_valid, 1'b0);
    tick();
    idle(); #2;
    chk1("fwait idv2", id_valid, 1'b0);
    chk1("fwait end ifr", if_ready, 1'b1);
    tick();

    // Flush in HOLD together with id_ready and a new PC.
    drv(0, 1, 64'h80000040, 0, 0, 0, 64'h0, 0);
    tick();
    drv(0, 0, 64'h0, 0, 1, 0, 64'h0, 0);
    tick();
    drv(0, 0, 64'h0, 0, 0, 1, 64'hAAAABBBB_00000013, 0);
    tick();
    drv(1, 1, 64'h80000048, 1, 0, 0, 64'h0, 0);
    #2;
    chk1("fhold idv", id_valid, 1'b1);
    chk64("fhold instr", 64'(id_instr), 64'h13);
    tick();
    idle(); #2;
    chk1("fhold drop idv", id_valid, 1'b0);
    chk1("fhold no acc", mif.mem_req_valid, 1'b0);
    tick();
    idle(); #2;
    chk1("fhold no acc2", mif.mem_req_valid, 1'b0);
    tick();

    // Reset asserted in WAIT after a delivered fetch.
    drv(0, 1, 64'h80000054, 0, 0, 0, 64'h0, 0);
    tick();
    drv(0, 0, 64'h0, 0, 1, 0, 64'h0, 0);
    tick();
    drv(0, 0, 64'h0, 0, 0, 1, 64'hCAFE0001_0000BEEF, 0);
    tick();
    drv(0, 1, 64'h80000058, 1, 0, 0, 64'h0, 0);
    #2;
    chk64("rw id_pc", id_pc, 64'h80000054);
    chk64("rw instr", 64'(id_instr), 64'hCAFE0001);
    tick();
    drv(0, 0, 64'h0, 0, 1, 0, 64'h0, 0);
    tick();
    idle();
    #1;
    reset = 1'b0;
    #1;
    chk1("arst req", mif.mem_req_valid, 1'b0);
    chk1("arst idv", id_valid, 1'b0);
    chk64("arst addr", mif.mem_addr, 64'h0);
    chk64("arst id_pc", id_pc, 64'h0);
    chk64("arst instr", 64'(id_instr), 64'h0);
    chk1("arst err", id_err, 1'b0);
    tick();
    #2;
    reset = 1'b1;
    tick();
    drv(0, 1, 64'h80000000, 0, 0, 0, 64'h0, 0);
    #2; chk1("post rst ifr", if_ready, 1'b1);
    tick();
    drv(0, 0, 64'h0, 0, 1, 0, 64'h0, 0);
    #2;
    chk1("post rst req", mif.mem_req_valid, 1'b1);
    chk64("post rst addr", mif.mem_addr, 64'h80000000);
    tick();
    drv(0, 0, 64'h0, 0, 0, 1, 64'h99999999_00000073, 0);
    #2; chk1("post rst idv0", id_valid, 1'b0);
    tick();
    drv(0, 0, 64'h0, 1, 0, 0, 64'h0, 0);
    #2;
    chk1("post rst idv", id_valid, 1'b1);
    chk64("post rst pc", id_pc, 64'h80000000);
    chk64("post rst instr", 64'(id_instr), 64'h73);
    tick();
    idle();
    tick();

    // Random traffic against the reference model.
    m_req = 0; m_out = 0; m_hold = 0; m_live = 0;
    m_pc = '0; h_pc = '0; h_ins = '0; h_err = 0;
    mem_busy = 0; mem_wait = 0; mem_data = '0; mem_err = 0;
    for (int c = 0; c < 3000; c++) begin
      rfl = ($urandom_range(0, 9) == 0);
      rpv = ($urandom_range(0, 9) < 7);
      rpc = {$urandom, $urandom} & ~64'h3;
      rir = ($urandom_range(0, 9) < 6);
      rrr = ($urandom_range(0, 9) < 6);
      rrv = mem_busy && (mem_wait == 0);
      rrd = rrv ? mem_data : {$urandom, $urandom};
      rre = rrv ? mem_err : 1'($urandom_range(0, 1));
      drv(rfl, rpv, rpc, rir, rrr, rrv, rrd, rre);
      #2;
      e_ifr = (~m_req & ~m_out & ~m_hold) | (m_hold & rir);
      chk1($sformatf("r%0d if_ready", c), if_ready, e_ifr);
      chk1($sformatf("r%0d req_valid", c), mif.mem_req_valid, m_req);
      chk1($sformatf("r%0d id_valid", c), id_valid, m_hold);
      if (m_req)
        chk64($sformatf("r%0d addr", c), mif.mem_addr,
              {m_pc[63:3], 3'b000});
      if (m_hold) begin
        chk64($sformatf("r%0d id_pc", c), id_pc, h_pc);
        chk64($sformatf("r%0d instr", c), 64'(id_instr), 64'(h_ins));
        chk1($sformatf("r%0d id_err", c), id_err, h_err);
      end
      acc = rpv & e_ifr & ~rfl;
      if (rrv) mem_busy = 0;
      else if (mem_busy) mem_wait--;
      if (m_hold && (rfl || rir)) m_hold = 0;
      if (m_out) begin
        if (rrv) begin
          m_out = 0;
          if (m_live && !rfl) begin
            m_hold = 1;
            h_pc   = m_pc;
            h_ins  = m_pc[2] ? mem_data[63:32] : mem_data[31:0];
            h_err  = mem_err;
          end
        end else if (rfl) begin
          m_live = 0;
        end
      end
      if (m_req) begin
        if (rfl) m_live = 0;
        if (rrr) begin
          m_req    = 0;
          m_out    = 1;
          mem_busy = 1;
          mem_wait = $urandom_range(0, 2);
          mem_data = mem_word({m_pc[63:3], 3'b000});
          mem_err  = ($urandom_range(0, 4) == 0);
        end
      end
      if (acc) begin
        m_pc   = rpc;
        m_req  = 1;
        m_live = 1;
      end
      tick();
    end

    idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
